// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS    = 8;
  localparam int DEF_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - serial line, consumer ack and received-byte/flag bundle
interface uart_rx_ctrl_if;

  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  modport master (
    output RX,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err,
    input  ovr_err
  );

  modport slave (
    input  RX,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err,
    output ovr_err
  );

endinterface

// File: rtl/rx_synch.sv
// rtl/rx_synch.sv - 2-FF synchronizer (resets to idle-high) with registered falling-edge pulse
module rx_synch (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic fall_q;

  // fall_q is high in exactly the first cycle that sync_o reads low
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      fall_q <= s2_q & ~s1_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 8N1 UART receiver: start validation, mid-bit sampling, framing/overrun flags
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 frm_err_q, frm_err_d;
  logic                 ovr_err_q, ovr_err_d;
  logic                 unread_q, unread_d;

  logic rx_s;
  logic rx_fall;
  logic sample;
  logic start_ok;
  logic bit_take;
  logic stop_good;
  logic stop_bad;

  rx_synch u_synch (
    .clk    (clk),
    .rst    (rst),
    .din_i  (bus.RX),
    .sync_o (rx_s),
    .fall_o (rx_fall)
  );

  // Start bit is checked half a bit in; every later sample is a full bit apart
  assign sample = (state_q == START) ? (baud_cnt_q == HALF_LAST)
                : (state_q != IDLE) && (baud_cnt_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_fall) state_d = START;
      START:   if (sample) state_d = rx_s ? IDLE : DATA;
      DATA:    if (sample && (bit_cnt_q == BIT_LAST)) state_d = STOP;
      STOP:    if (sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ok  = 1'b0;
    bit_take  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      START:   start_ok = sample && !rx_s;
      DATA:    bit_take = sample;
      STOP: begin
        stop_good = sample && rx_s;
        stop_bad  = sample && !rx_s;
      end
      default: ;
    endcase
  end

  // unread_q remembers an unacknowledged byte even after rdy drops at the next start bit
  always_comb begin
    baud_cnt_d = (state_q == IDLE || sample) ? '0 : baud_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    frm_err_d  = frm_err_q;
    ovr_err_d  = ovr_err_q;
    unread_d   = unread_q;

    if (start_ok) begin
      bit_cnt_d = '0;
      rdy_d     = 1'b0;
    end
    if (bit_take) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
    end
    if (bus.clr_rdy) begin
      rdy_d     = 1'b0;
      frm_err_d = 1'b0;
      ovr_err_d = 1'b0;
      unread_d  = 1'b0;
    end
    if (stop_good) begin
      rx_data_d = shreg_q;
      rdy_d     = 1'b1;
      unread_d  = 1'b1;
      if (unread_q) ovr_err_d = 1'b1;
    end
    if (stop_bad) frm_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      unread_q   <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
      unread_q   <= unread_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with BAUD_DIV=16
module tb_uart_rx_ctrl;

  localparam int B   = 16;
  localparam int LAT = 2 + B / 2 + 9 * B + 1;

  typedef struct {
    logic [7:0] data;
    logic       rdy;
    logic       frm;
    logic       ovr;
    logic       ack;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic r, input logic f,
                              input logic o, input logic a);
    exp_t e;
    e.data = d; e.rdy = r; e.frm = f; e.ovr = o; e.ack = a; e.cyc = 0;
    return e;
  endfunction

  // Call just after a negedge; the frame occupies exactly 10*B negedges
  task automatic send_frame(input logic [7:0] d, input logic stop, input exp_t e);
    e.cyc = cyc + LAT;
    sbq.push_back(e);
    bus.RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      repeat (B) @(negedge clk);
    end
    bus.RX = stop;
    repeat (B) @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every rising rdy or frm_err must match the head of the scoreboard
  initial begin
    logic prdy = 1'b0;
    logic pfrm = 1'b0;
    logic mon_ack = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_ack) begin
        bus.clr_rdy = 1'b0;
        mon_ack = 1'b0;
      end
      if ((bus.rdy && !prdy) || (bus.frm_err && !pfrm)) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event rdy=%0b frm_err=%0b rx_data=%0h required=no event",
                   bus.rdy, bus.frm_err, bus.rx_data);
        end else begin
          e = sbq.pop_front();
          chk("rx_data", int'(bus.rx_data), int'(e.data));
          chk("rdy", int'(bus.rdy), int'(e.rdy));
          chk("frm_err", int'(bus.frm_err), int'(e.frm));
          chk("ovr_err", int'(bus.ovr_err), int'(e.ovr));
          chk("latency_cycle", cyc, e.cyc);
          if (e.ack) begin
            bus.clr_rdy = 1'b1;
            mon_ack = 1'b1;
          end
        end
      end
      prdy = bus.rdy;
      pfrm = bus.frm_err;
    end
  end

  initial begin
    logic [7:0] part;
    bus.RX = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", int'(bus.rx_data), 0);
    chk("reset_rdy", int'(bus.rdy), 0);
    chk("reset_frm_err", int'(bus.frm_err), 0);
    chk("reset_ovr_err", int'(bus.ovr_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, mk(8'hA5, 1, 0, 0, 1));
    repeat (20) @(negedge clk);

    send_frame(8'h00, 1'b1, mk(8'h00, 1, 0, 0, 1));
    send_frame(8'hFF, 1'b1, mk(8'hFF, 1, 0, 0, 1));
    send_frame(8'h01, 1'b1, mk(8'h01, 1, 0, 0, 1));
    repeat (20) @(negedge clk);

    bus.RX = 1'b0;
    repeat (3) @(negedge clk);
    bus.RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdy", int'(bus.rdy), 0);
    chk("glitch_frm_err", int'(bus.frm_err), 0);
    send_frame(8'h3C, 1'b1, mk(8'h3C, 1, 0, 0, 1));
    repeat (20) @(negedge clk);

    send_frame(8'h55, 1'b0, mk(8'h3C, 0, 1, 0, 0));
    bus.RX = 1'b1;
    repeat (10) @(negedge clk);
    chk("frm_err_held", int'(bus.frm_err), 1);
    pulse_clr();
    chk("frm_err_cleared", int'(bus.frm_err), 0);
    repeat (10) @(negedge clk);

    send_frame(8'h11, 1'b1, mk(8'h11, 1, 0, 0, 0));
    repeat (10) @(negedge clk);
    fork
      send_frame(8'h22, 1'b1, mk(8'h22, 1, 0, 1, 0));
      begin
        repeat (LAT - 1) @(negedge clk);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
      end
    join
    chk("ovr_rdy_set_wins", int'(bus.rdy), 1);
    chk("ovr_err_held", int'(bus.ovr_err), 1);
    chk("ovr_rx_data", int'(bus.rx_data), 8'h22);
    pulse_clr();
    chk("ovr_err_cleared", int'(bus.ovr_err), 0);
    chk("ovr_rdy_cleared", int'(bus.rdy), 0);
    repeat (10) @(negedge clk);

    part = 8'hC3;
    bus.RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.RX = part[i];
      repeat (B) @(negedge clk);
    end
    bus.RX = part[4];
    repeat (B / 2) @(negedge clk);
    rst = 1'b1;
    bus.RX = 1'b1;
    @(negedge clk);
    chk("midrst_rx_data", int'(bus.rx_data), 0);
    chk("midrst_rdy", int'(bus.rdy), 0);
    chk("midrst_frm_err", int'(bus.frm_err), 0);
    chk("midrst_ovr_err", int'(bus.ovr_err), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1, mk(8'h7E, 1, 0, 0, 1));

    for (int n = 0; n < 400 && sbq.size() != 0; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
